fma_vector_checker: RTL
=======================

Name: fma_vector_checker

Overview:
- Synthesizable self-checking vector engine for the fma16 family, generalised to FLEN-bit operands and pipelined FMA units.
- Reads packed vectors from an external synchronous memory, drives the FMA under test, queues expected result/flags in an internal FIFO, and compares them against DUT outputs returned under a valid strobe.
- Keeps error counts and captures the first failure.
- Sits beside the FMA on FPGA/emulation targets and in the fma16 exercise bench.

Parameters:
- FLEN, 16, operand/result width (16/32/64).
- DEPTH, 8, expected-FIFO entries = max outstanding DUT ops (power of 2, >=2).
- ADDRW, 17, vector memory address width.
- CNTW, 32, width of vector/error counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  pulse: begin run (accepted in IDLE or DONE only)
- num_vectors  in  CNTW  vectors to run, sampled on accepted start
- vec_rd  out  1  memory read enable
- vec_addr  out  ADDRW  memory address
- vec_data  in  4*FLEN+12  {x,y,z,ctrl[7:0],rexp,flagsexp[3:0]}, valid 1 cycle after vec_rd
- dut_x, dut_y, dut_z  out  FLEN  operands (registered)
- dut_mul, dut_add, dut_negp, dut_negz  out  1  ctrl[3:0]
- dut_roundmode  out  2  ctrl[5:4]
- dut_in_valid  out  1  operands valid this cycle
- dut_result  in  FLEN  DUT result
- dut_flags  in  4  {invalid,overflow,underflow,inexact}
- dut_out_valid  in  1  result/flags valid
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- vec_checked  out  CNTW  comparisons performed
- errors  out  CNTW  mismatches, saturating
- proto_err  out  1  sticky: dut_out_valid while FIFO empty
- first_err_idx  out  CNTW  index of first mismatch
- first_err_result  out  FLEN  DUT result of first mismatch
- first_err_flags  out  4  DUT flags of first mismatch

Behaviour:
- Reset clears every output and internal counter, FIFO and pointers to 0, and forces state IDLE.
- Reset mid-run abandons all in-flight work.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE --start--> RUN, or straight to DONE if num_vectors==0.
  - Any accepted start clears counters, errors, proto_err and the first_err_* fields.
  - start while busy is ignored.
- RUN: issue index i (0..num_vectors-1).
  - Cycle n: vec_rd=1, vec_addr=i. Only issued when FIFO occupancy + reads in flight < DEPTH.
  - Cycle n+1: operands registered from vec_data, and {rexp,flagsexp,i} pushed to FIFO.
  - Cycle n+2: dut_in_valid=1 with those operands.
  - Full throughput: one vector per cycle when not stalled.
- RUN -> DRAIN after the read of index num_vectors-1 is issued.
- DRAIN -> DONE in the cycle after the FIFO empties with no reads in flight.
- DONE holds all outputs until reset or start.
- Checking:
  - Each cycle with dut_out_valid and FIFO non-empty: pop the head and compare dut_result != rexp (exact bit compare, no NaN canonicalisation).
  - Each comparison increments vec_checked.
  - A mismatch increments errors, which saturates at all-ones.
  - On the first mismatch of a run, capture first_err_*.
- dut_out_valid with FIFO empty: set proto_err; nothing popped or counted.
- Push and pop in the same cycle are allowed: occupancy unchanged. Pointers wrap modulo DEPTH.
- DUT results must return in issue order. Latency is arbitrary; throughput is bounded by DEPTH.
- Results arriving in DONE/IDLE are treated as FIFO-empty and set proto_err.

Optional Feature:
- FMA_CHK_FLAGS_EN defined: mismatch = (dut_result != rexp) | (dut_flags != flagsexp).
- Undefined: flags are ignored in the comparison and flagsexp is not stored in the FIFO.
- first_err_flags still reports DUT flags in both cases.

Decomposition:
- Shared package fma_chk_pkg:
  - state enum.
  - Vector field offsets/widths as localparams derived from FLEN.
  - Ctrl bit positions (ROUNDMODE=5:4, MUL=3, ADD=2, NEGP=1, NEGZ=0).
  - Flag bit order.
- One sub-module, fma_chk_fifo: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, full, empty, count, and the same clk/reset.

Test Plan:
- num_vectors=4, FLEN=16, zero-latency DUT model returning rexp -> done after drain, vec_checked=4, errors=0, proto_err=0.
- Vector 2 expects 3C00 but the DUT returns 3C01 -> errors=1, first_err_idx=2, first_err_result=3C01.
- DUT latency 12 with DEPTH=8 -> vec_rd stalls at 8 outstanding, no FIFO overflow, all 20 vectors checked, errors=0.
- num_vectors=0 start -> DONE one cycle later, vec_rd never asserted, vec_checked=0.
- Assert reset during RUN after 3 issues, then start with num_vectors=5 -> counters restart from 0, 5 checked.
- Spurious dut_out_valid in IDLE -> proto_err=1 and errors unchanged. With FMA_CHK_FLAGS_EN, a flags-only mismatch (flags 0001 vs expected 0000) gives errors=1; without the macro it gives errors=0.

Source files
------------

// File: rtl/fma_chk_pkg.sv
// fma_chk_pkg: shared definitions for the fma_vector_checker slice.
//   - checker state encoding
//   - packed test-vector layout {x, y, z, ctrl[7:0], rexp, flagsexp[3:0]},
//     expressed as field offsets computed from the operand width
//   - ctrl and flag bit positions
package fma_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

  localparam int FLAGS_W = 4;
  localparam int CTRL_W  = 8;

  // ctrl byte bit positions
  localparam int CTRL_NEGZ   = 0;
  localparam int CTRL_NEGP   = 1;
  localparam int CTRL_ADD    = 2;
  localparam int CTRL_MUL    = 3;
  localparam int CTRL_RM_LSB = 4;
  localparam int CTRL_RM_W   = 2;

  // flag nibble bit order: {invalid, overflow, underflow, inexact}
  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  // Vector field offsets (LSB positions) for a given operand width.
  function automatic int vec_width(input int flen);
    return 4 * flen + CTRL_W + FLAGS_W;
  endfunction

  function automatic int flags_lsb(input int flen);
    return 0 * flen;
  endfunction

  function automatic int rexp_lsb(input int flen);
    return FLAGS_W + 0 * flen;
  endfunction

  function automatic int ctrl_lsb(input int flen);
    return FLAGS_W + flen;
  endfunction

  function automatic int z_lsb(input int flen);
    return FLAGS_W + CTRL_W + flen;
  endfunction

  function automatic int y_lsb(input int flen);
    return FLAGS_W + CTRL_W + 2 * flen;
  endfunction

  function automatic int x_lsb(input int flen);
    return FLAGS_W + CTRL_W + 3 * flen;
  endfunction

endpackage

// File: rtl/fma_chk_fifo.sv
// fma_chk_fifo: synchronous show-ahead FIFO holding expected results.
// Ports:
//   clk, reset      clock, asynchronous active-high reset (clears all state)
//   push, wdata     write strobe and data (ignored when full)
//   pop, rdata      read strobe (ignored when empty); rdata is the current head
//   full, empty     occupancy flags
//   count           entries held (0..DEPTH)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fma_chk_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage, pointers and occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});
  assign count = count_r;

endmodule

// File: rtl/fma_vector_checker.sv
// fma_vector_checker: self-checking vector engine for an FLEN-bit FMA unit.
// Reads packed vectors from a synchronous memory (1-cycle read latency),
// drives the FMA under test, queues expected results in fma_chk_fifo and
// compares them with in-order DUT results returned under dut_out_valid.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, num_vectors    begin a run (accepted in IDLE/DONE only)
//   vec_rd/vec_addr/vec_data   vector memory interface
//   dut_x/y/z, dut_mul/add/negp/negz, dut_roundmode, dut_in_valid  to FMA
//   dut_result, dut_flags, dut_out_valid                           from FMA
//   busy, done, vec_checked, errors, proto_err, first_err_*        status
// Build option: define FMA_CHK_FLAGS_EN to include the flags in the
// comparison (otherwise expected flags are neither stored nor compared).
module fma_vector_checker
  import fma_chk_pkg::*;
#(
  parameter int FLEN  = 16,
  parameter int DEPTH = 8,
  parameter int ADDRW = 17,
  parameter int CNTW  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNTW-1:0]      num_vectors,
  output logic                 vec_rd,
  output logic [ADDRW-1:0]     vec_addr,
  input  logic [4*FLEN+11:0]   vec_data,
  output logic [FLEN-1:0]      dut_x,
  output logic [FLEN-1:0]      dut_y,
  output logic [FLEN-1:0]      dut_z,
  output logic                 dut_mul,
  output logic                 dut_add,
  output logic                 dut_negp,
  output logic                 dut_negz,
  output logic [1:0]           dut_roundmode,
  output logic                 dut_in_valid,
  input  logic [FLEN-1:0]      dut_result,
  input  logic [3:0]           dut_flags,
  input  logic                 dut_out_valid,
  output logic                 busy,
  output logic                 done,
  output logic [CNTW-1:0]      vec_checked,
  output logic [CNTW-1:0]      errors,
  output logic                 proto_err,
  output logic [CNTW-1:0]      first_err_idx,
  output logic [FLEN-1:0]      first_err_result,
  output logic [3:0]           first_err_flags
);

  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int OW        = CW + 1;
  localparam int X_LSB     = x_lsb(FLEN);
  localparam int Y_LSB     = y_lsb(FLEN);
  localparam int Z_LSB     = z_lsb(FLEN);
  localparam int C_LSB     = ctrl_lsb(FLEN);
  localparam int R_LSB     = rexp_lsb(FLEN);
  localparam int F_LSB     = flags_lsb(FLEN);
`ifdef FMA_CHK_FLAGS_EN
  localparam int ENT_W     = FLEN + FLAGS_W + CNTW;
`else
  localparam int ENT_W     = FLEN + CNTW;
`endif

  chk_state_e       state_r;
  logic [CNTW-1:0]  num_r;
  logic [CNTW-1:0]  issue_idx_r;
  logic [CNTW-1:0]  rd_idx_r;
  logic [CNTW-1:0]  data_idx_r;
  logic             vec_rd_r;
  logic [ADDRW-1:0] vec_addr_r;
  logic             data_vld_r;
  logic [FLEN-1:0]  dut_x_r, dut_y_r, dut_z_r;
  logic [CTRL_W-1:0] dut_ctrl_r;
  logic             dut_in_valid_r;
  logic             busy_r, done_r;
  logic [CNTW-1:0]  vec_checked_r, errors_r, first_err_idx_r;
  logic             proto_err_r, have_err_r;
  logic [FLEN-1:0]  first_err_result_r;
  logic [3:0]       first_err_flags_r;

  logic [CW-1:0]    fifo_count_s;
  logic             fifo_full_s, fifo_empty_s;
  logic             push_s, pop_s, proto_s, mismatch_s, can_issue_s;
  logic [OW-1:0]    outstanding_s;
  logic [ENT_W-1:0] push_data_s, head_s;
  logic [FLEN-1:0]  head_rexp_s;
  logic [CNTW-1:0]  head_idx_s;
  logic             unused_s;

  // Entries: {rexp, [flagsexp], index}; index sits in the low bits.
`ifdef FMA_CHK_FLAGS_EN
  logic [FLAGS_W-1:0] head_flags_s;
  assign push_data_s  = {vec_data[R_LSB +: FLEN], vec_data[F_LSB +: FLAGS_W], data_idx_r};
  assign head_flags_s = head_s[CNTW +: FLAGS_W];
  assign mismatch_s   = (dut_result != head_rexp_s) || (dut_flags != head_flags_s);
  assign unused_s     = ^vec_data[C_LSB + 6 +: 2];
`else
  assign push_data_s  = {vec_data[R_LSB +: FLEN], data_idx_r};
  assign mismatch_s   = (dut_result != head_rexp_s);
  assign unused_s     = ^{vec_data[C_LSB + 6 +: 2], vec_data[F_LSB +: FLAGS_W]};
`endif
  assign head_rexp_s = head_s[ENT_W-1 -: FLEN];
  assign head_idx_s  = head_s[CNTW-1:0];

  // vec_data is valid in the cycle after vec_rd; that is when it is pushed.
  assign push_s = data_vld_r && !fifo_full_s;

  // Issue gating and result classification.
  always_comb begin
    outstanding_s = OW'(fifo_count_s) + OW'(vec_rd_r) + OW'(data_vld_r);
    can_issue_s   = (outstanding_s < OW'(DEPTH));
    // Results outside RUN/DRAIN are treated as arriving with an empty FIFO.
    if ((state_r == ST_RUN) || (state_r == ST_DRAIN)) begin
      pop_s = dut_out_valid && !fifo_empty_s;
    end else begin
      pop_s = 1'b0;
    end
    proto_s = dut_out_valid && !pop_s;
  end

  fma_chk_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .wdata (push_data_s),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Control FSM, read/operand pipeline and result checking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r            <= ST_IDLE;
      num_r              <= {CNTW{1'b0}};
      issue_idx_r        <= {CNTW{1'b0}};
      rd_idx_r           <= {CNTW{1'b0}};
      data_idx_r         <= {CNTW{1'b0}};
      vec_rd_r           <= 1'b0;
      vec_addr_r         <= {ADDRW{1'b0}};
      data_vld_r         <= 1'b0;
      dut_x_r            <= {FLEN{1'b0}};
      dut_y_r            <= {FLEN{1'b0}};
      dut_z_r            <= {FLEN{1'b0}};
      dut_ctrl_r         <= {CTRL_W{1'b0}};
      dut_in_valid_r     <= 1'b0;
      busy_r             <= 1'b0;
      done_r             <= 1'b0;
      vec_checked_r      <= {CNTW{1'b0}};
      errors_r           <= {CNTW{1'b0}};
      proto_err_r        <= 1'b0;
      have_err_r         <= 1'b0;
      first_err_idx_r    <= {CNTW{1'b0}};
      first_err_result_r <= {FLEN{1'b0}};
      first_err_flags_r  <= 4'h0;
    end else begin
      // Read pipeline: cycle n read, n+1 capture/push, n+2 operands valid.
      data_vld_r     <= vec_rd_r;
      data_idx_r     <= rd_idx_r;
      dut_in_valid_r <= data_vld_r;
      if (data_vld_r) begin
        dut_x_r    <= vec_data[X_LSB +: FLEN];
        dut_y_r    <= vec_data[Y_LSB +: FLEN];
        dut_z_r    <= vec_data[Z_LSB +: FLEN];
        dut_ctrl_r <= vec_data[C_LSB +: CTRL_W];
      end

      if (pop_s) begin
        vec_checked_r <= vec_checked_r + CNTW'(1'b1);
        if (mismatch_s) begin
          if (errors_r != {CNTW{1'b1}}) begin
            errors_r <= errors_r + CNTW'(1'b1);
          end
          if (!have_err_r) begin
            have_err_r         <= 1'b1;
            first_err_idx_r    <= head_idx_s;
            first_err_result_r <= dut_result;
            first_err_flags_r  <= dut_flags;
          end
        end
      end
      if (proto_s) begin
        proto_err_r <= 1'b1;
      end

      case (state_r)
        ST_IDLE, ST_DONE: begin
          vec_rd_r <= 1'b0;
          if (start) begin
            // Later assignments override the checking updates above.
            vec_checked_r      <= {CNTW{1'b0}};
            errors_r           <= {CNTW{1'b0}};
            proto_err_r        <= 1'b0;
            have_err_r         <= 1'b0;
            first_err_idx_r    <= {CNTW{1'b0}};
            first_err_result_r <= {FLEN{1'b0}};
            first_err_flags_r  <= 4'h0;
            num_r              <= num_vectors;
            issue_idx_r        <= {CNTW{1'b0}};
            if (num_vectors == {CNTW{1'b0}}) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (can_issue_s) begin
            vec_rd_r    <= 1'b1;
            vec_addr_r  <= ADDRW'(issue_idx_r);
            rd_idx_r    <= issue_idx_r;
            issue_idx_r <= issue_idx_r + CNTW'(1'b1);
            if (issue_idx_r == (num_r - CNTW'(1'b1))) begin
              state_r <= ST_DRAIN;
            end
          end else begin
            vec_rd_r <= 1'b0;
          end
        end
        ST_DRAIN: begin
          vec_rd_r <= 1'b0;
          if (fifo_empty_s && !vec_rd_r && !data_vld_r) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          vec_rd_r <= 1'b0;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

  assign vec_rd           = vec_rd_r;
  assign vec_addr         = vec_addr_r;
  assign dut_x            = dut_x_r;
  assign dut_y            = dut_y_r;
  assign dut_z            = dut_z_r;
  assign dut_mul          = dut_ctrl_r[CTRL_MUL];
  assign dut_add          = dut_ctrl_r[CTRL_ADD];
  assign dut_negp         = dut_ctrl_r[CTRL_NEGP];
  assign dut_negz         = dut_ctrl_r[CTRL_NEGZ];
  assign dut_roundmode    = dut_ctrl_r[CTRL_RM_LSB +: CTRL_RM_W];
  assign dut_in_valid     = dut_in_valid_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign vec_checked      = vec_checked_r;
  assign errors           = errors_r;
  assign proto_err        = proto_err_r;
  assign first_err_idx    = first_err_idx_r;
  assign first_err_result = first_err_result_r;
  assign first_err_flags  = first_err_flags_r;

endmodule
